// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings and the responder FSM state type.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_lane_format.sv
// Byte-lane steering for RV32I loads/stores: merges store data into the old
// word, extracts/extends load data, and flags misalignment or illegal funct3.
module mem_lane_format
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] st_word,
  output logic [31:0] ld_word,
  output logic        err
);

  logic [4:0]  sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign sh      = {addr_lo, 3'b000};
  assign ld_byte = old_word[sh +: 8];
  assign ld_half = old_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    st_word = old_word;
    ld_word = '0;
    err     = 1'b0;
    if (we) begin
      case (func3)
        F3_B: st_word = (old_word & ~(32'h0000_00ff << sh)) | ({24'b0, wdata[7:0]} << sh);
        F3_H: begin
          if (addr_lo[0]) err = 1'b1;
          else st_word = (old_word & ~(32'h0000_ffff << sh)) | ({16'b0, wdata[15:0]} << sh);
        end
        F3_W: begin
          if (addr_lo != 2'b00) err = 1'b1;
          else st_word = wdata;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (func3)
        F3_B:  ld_word = {{24{ld_byte[7]}}, ld_byte};
        F3_BU: ld_word = {24'b0, ld_byte};
        F3_H: begin
          if (addr_lo[0]) err = 1'b1;
          else ld_word = {{16{ld_half[15]}}, ld_half};
        end
        F3_HU: begin
          if (addr_lo[0]) err = 1'b1;
          else ld_word = {16'b0, ld_half};
        end
        F3_W: begin
          if (addr_lo != 2'b00) err = 1'b1;
          else ld_word = old_word;
        end
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, word array
// accessed on the edge entering RESP, single-cycle response strobe.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // With LATENCY==1 the access happens on the accept edge, before the latch
  // holds the request, so the live inputs feed the access while IDLE.
  logic                  op_we;
  logic [31:0]           op_addr, op_wdata;
  logic [2:0]            op_f3;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           st_word, ld_word;
  logic                  fmt_err, enter_resp, mem_we;
  logic                  unused_addr_hi;

  assign op_we    = (state_q == IDLE) ? req_we    : we_q;
  assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign op_f3    = (state_q == IDLE) ? req_func3 : f3_q;
  assign idx      = op_addr[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^op_addr[31:DEPTH_LOG2+2];

  mem_lane_format u_fmt (
    .we       (op_we),
    .func3    (op_f3),
    .addr_lo  (op_addr[1:0]),
    .wdata    (op_wdata),
    .old_word (mem[idx]),
    .st_word  (st_word),
    .ld_word  (ld_word),
    .err      (fmt_err)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_func3;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP);
    if (enter_resp) begin
      rdata_d = (fmt_err || op_we) ? 32'h0 : ld_word;
      err_d   = fmt_err;
    end
  end

  // Reset on the RESP-entry edge must also suppress the commit.
  assign mem_we = enter_resp & op_we & ~fmt_err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= st_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
  import riscv_mem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_func3;

  logic        v1, rdy1, we1, rv1, er1;
  logic [31:0] a1, wd1, rd1;
  logic [2:0]  f1;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] m [16];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_LOG2(4), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
    .req_we(we1), .req_addr(a1), .req_wdata(wd1), .req_func3(f1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: size from funct3, lane mask and shift in plain arithmetic.
  function automatic void ref_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int sz, sh, wi;
    logic [31:0] mask, v;
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    wi   = int'(a[5:2]);
    sh   = 8 * int'(a[1:0]);
    mask = (sz == 4) ? 32'hffff_ffff : ((32'd1 << (8 * sz)) - 32'd1);
    err  = we ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((int'(a[1:0]) % sz) != 0) err = 1'b1;
    rd = 32'h0;
    if (err) return;
    if (we) begin
      m[wi] = (m[wi] & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      v = (m[wi] >> sh) & mask;
      if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v | ~mask;
      rd = v;
    end
  endfunction

  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic err);
    logic [31:0] erd;
    logic        eerr;
    int          k;
    bit          ok;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_func3 = f3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0; rd = 32'h0; err = 1'b1;
      return;
    end
    @(posedge clk);
    ref_op(we, a, wd, f3, erd, eerr);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
    k = 1;
    while (!resp_valid && k < 20) begin
      chk("busy_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(LAT));
    chk("resp_ready", 32'(req_ready), 32'd0);
    chk("resp_err", 32'(resp_err), 32'(eerr));
    chk("resp_rdata", resp_rdata, erd);
    rd = resp_rdata; err = resp_err;
    @(negedge clk);
    chk("ready_after", 32'(req_ready), 32'd1);
    chk("valid_after", 32'(resp_valid), 32'd0);
    chk("rdata_hold", resp_rdata, erd);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          nresp;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_func3 = '0;
    v1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0; f1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), $urandom, F3_W, rd, er);

    xact(1'b1, 32'h10, 32'hdeadbeef, F3_W, rd, er);  chk("sw_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, er);         chk("lw_deadbeef", rd, 32'hdeadbeef);
    xact(1'b1, 32'h13, 32'h80, F3_B, rd, er);
    xact(1'b0, 32'h13, 32'h0, F3_B, rd, er);         chk("lb_13", rd, 32'hffffff80);
    xact(1'b0, 32'h13, 32'h0, F3_BU, rd, er);        chk("lbu_13", rd, 32'h00000080);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, er);         chk("lw_after_sb", rd, 32'h80adbeef);
    xact(1'b1, 32'h12, 32'h1234, F3_H, rd, er);
    xact(1'b0, 32'h12, 32'h0, F3_HU, rd, er);        chk("lhu_12", rd, 32'h00001234);
    xact(1'b0, 32'h11, 32'h0, F3_H, rd, er);         chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, er);         chk("lw_after_sh", rd, 32'h1234beef);

    // req_valid held high: accepts every LAT+1 cycles
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_func3 = F3_W;
    nresp = 0;
    for (int i = 0; i < 12; i++) begin
      chk("ready_pattern", 32'(req_ready), 32'((i % 3) == 0));
      if (resp_valid) begin
        nresp++;
        chk("stream_rdata", resp_rdata, 32'h1234beef);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("stream_count", 32'(nresp), 32'd4);
    @(negedge clk);

    // reset while BUSY, on the edge that would enter RESP
    xact(1'b1, 32'h20, 32'h55aa55aa, F3_W, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hffffffff; req_func3 = F3_W;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("abort_ready", 32'(req_ready), 32'd1);
    xact(1'b0, 32'h20, 32'h0, F3_W, rd, er);         chk("abort_no_commit", rd, 32'h55aa55aa);

    xact(1'b1, 32'h1010, 32'hcafef00d, F3_W, rd, er);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, er);         chk("alias_1010", rd, 32'hcafef00d);
    xact(1'b0, 32'h14, 32'h0, F3_W, rd, er);
    a = rd;
    xact(1'b1, 32'h14, 32'h12345678, 3'b011, rd, er); chk("ill_st_err", 32'(er), 32'd1);
    xact(1'b0, 32'h14, 32'h0, F3_W, rd, er);         chk("ill_st_nowrite", rd, a);

    for (int i = 0; i < 150; i++) begin
      a = ($urandom & 32'hffff_f000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      xact(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), rd, er);
    end

    // LATENCY=1 instance: response in the cycle right after acceptance
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b1; a1 = 32'h8; wd1 = 32'h13572468; f1 = F3_W;
    chk("l1_ready", 32'(rdy1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    chk("l1_valid", 32'(rv1), 32'd1);
    chk("l1_err", 32'(er1), 32'd0);
    chk("l1_resp_ready", 32'(rdy1), 32'd0);
    @(negedge clk);
    chk("l1_valid_off", 32'(rv1), 32'd0);
    chk("l1_ready_back", 32'(rdy1), 32'd1);
    v1 = 1'b1; we1 = 1'b0; a1 = 32'h8; f1 = F3_W;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    chk("l1_lw_valid", 32'(rv1), 32'd1);
    chk("l1_lw_rdata", rd1, 32'h13572468);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the pipeline's data-memory port: accepts one load or store request at a time from the memory stage, waits a fixed access latency, performs the RV32I byte/half/word access on an internal word-addressed array, and returns a single-cycle response. It lets the pipeline be exercised against a multi-cycle memory instead of a zero-latency combinational one. The stall and flush logic of the pipeline consumes `req_ready`/`resp_valid`.

## Interface
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words in the array.
- `LATENCY`, default 2: cycles from request acceptance to response; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; lane-0 justified.
- `req_func3`  in  3  RV32I funct3 of the load or store.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load result, already extended; 0 for stores and errors.
- `resp_err`  out  1  request rejected: misaligned address or illegal funct3.

## Operation
- States are IDLE, BUSY and RESP.
- `req_ready` = 1 only in IDLE.
- A request is accepted when `req_valid & req_ready`. On acceptance, `req_we`, `req_addr`, `req_wdata` and `req_func3` are latched. The inputs are don't-care afterwards.
- IDLE to BUSY on acceptance; the latency counter loads `LATENCY-1`. If `LATENCY==1`, IDLE goes straight to RESP.
- In BUSY, the counter decrements each cycle. When the counter reaches 0, the next state is RESP.
- RESP lasts exactly one cycle with `resp_valid=1`, then returns to IDLE. There is no response back-pressure.
- The array access happens on the edge entering RESP, and `resp_rdata`/`resp_err` are registered on that same edge.
- Word index is `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias and wrap.
- Loads:
  - funct3 000 (LB): byte selected by `addr[1:0]`, sign-extended.
  - funct3 001 (LH): half selected by `addr[1]`, sign-extended.
  - funct3 010 (LW): full word.
  - funct3 100 (LBU): byte, zero-extended.
  - funct3 101 (LHU): half, zero-extended.
- Stores: funct3 000 (SB), 001 (SH) or 010 (SW). Only the addressed byte lanes are written, using `wdata` bits [7:0], [15:0] or [31:0] shifted to that lane. Other lanes keep their value.
- Error cases:
  - Halfword access with `addr[0]=1` is an error.
  - Word access with `addr[1:0]!=0` is an error.
  - Store funct3 outside {000,001,010} is an error.
  - Load funct3 outside {000,001,010,100,101} is an error.
  - On error: no array write, `resp_rdata=0`, `resp_err=1`.

## Timing
- Reset values: state IDLE, counter 0, `req_ready=1` in the first cycle after reset, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`. Array contents are not cleared.
- Latency: if a request is accepted at edge T, `resp_valid` is high during the cycle after edge T+LATENCY-1 (i.e. LATENCY cycles later). `resp_valid` is low in every other cycle.
- Throughput: one request per LATENCY+1 cycles. `req_ready` rises in the cycle after the RESP cycle.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Reset mid-operation (BUSY or RESP): the transaction is aborted with no response, and a pending store is not committed. If `rst` is asserted on the same edge that would enter RESP, reset wins.
- `req_valid` asserted while `req_ready=0` is ignored. The requester must hold the request until it is accepted.
- `resp_rdata` and `resp_err` hold their last values outside RESP. Only `resp_valid` qualifies them.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - state enum `mem_state_t`: IDLE, BUSY, RESP.
- Combinational sub-module `mem_lane_format` holds:
  - inputs: `func3`, `addr[1:0]`, `wdata`, old word;
  - outputs: merged store word, extended load word, error flag.
- The top level holds the FSM, the counter, the request latch and the array.

## Test plan
- Reset, then SW of `0xDEADBEEF` to addr 0x10 with LATENCY=2 -> `resp_valid` exactly 2 cycles after acceptance, `resp_err=0`; a following LW of 0x10 returns `0xDEADBEEF`.
- SB of `0x80` to 0x13, then LB 0x13 and LBU 0x13 -> `0xFFFFFF80` and `0x00000080`; LW 0x10 -> `0x80ADBEEF`.
- SH of `0x1234` to 0x12 -> LHU 0x12 = `0x00001234`; LH 0x11 -> `resp_err=1`, `rdata=0`, and a subsequent LW 0x10 is unchanged.
- `req_valid` held high continuously -> `req_ready` pattern is 1,0,0,1 per request with LATENCY=2; no request is lost or duplicated; LATENCY=1 gives a response the cycle after acceptance.
- `rst` pulsed while in BUSY during an SW of `0xFFFFFFFF` to 0x20 -> no `resp_valid`; after reset, LW 0x20 returns the old value.
- Address 0x1010 with DEPTH_LOG2=10 -> aliases to 0x10; an illegal store funct3 of 011 -> `resp_err=1` with no write.
